// File: rtl/tt_sweep_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tt_sweep_checker                                          |
// | Purpose  : Sweeps every input vector of a combinational block in     |
// |            ascending order and waits SETTLE_CYC cycles per vector.   |
// |            Samples Y, builds the captured truth table and counts     |
// |            mismatches against a latched golden table.                |
// | Options  : TT_STOP_ON_FAIL_EN - end the sweep on first mismatch.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tt_sweep_checker #(
  parameter int N_IN       = 3,
  parameter int SETTLE_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   expected,
  input  logic                   y_in,
  output logic [N_IN-1:0]        abc_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [(1<<N_IN)-1:0]   captured,
  output logic [N_IN:0]          err_count
);

  localparam int c_num_vec = 1 << N_IN;
  localparam int c_cnt_w   = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SETTLE_CYC - 1);
  localparam logic [N_IN-1:0]    c_idx_last = N_IN'(c_num_vec - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]           r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [N_IN-1:0]      r_idx;
  logic [c_num_vec-1:0] r_exp;
  logic [c_num_vec-1:0] r_cap;
  logic [N_IN:0]        r_err;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_pass;

  logic                 w_mis;
  logic                 w_last;
  logic [N_IN:0]        w_err_nxt;

  // Mismatch of the current sample and the error count it would produce.
  always_comb begin
    w_mis     = y_in ^ r_exp[r_idx];
    w_last    = (r_idx == c_idx_last);
    w_err_nxt = r_err + {{N_IN{1'b0}}, w_mis};
  end

  // Sweep sequencer: vector index doubles as the registered stimulus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_exp   <= '0;
      r_cap   <= '0;
      r_err   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_exp   <= expected;
            r_cap   <= '0;
            r_err   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_cnt_last) begin
            r_state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          r_cap[r_idx] <= y_in;
          r_err        <= w_err_nxt;
`ifdef TT_STOP_ON_FAIL_EN
          if (w_last || w_mis) begin
`else
          if (w_last) begin
`endif
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_nxt == '0);
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_cnt   <= '0;
            r_state <= S_SETTLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign abc_out   = r_idx;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign captured  = r_cap;
  assign err_count = r_err;

endmodule
`default_nettype wire

// File: tb/tb_tt_sweep_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_tt_sweep_checker                                       |
// | Purpose  : Self-checking bench for tt_sweep_checker with a truth-    |
// |            table DUT model and a table-level reference model.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_tt_sweep_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Default instance: N_IN=3, SETTLE_CYC=2
  logic       start1 = 1'b0;
  logic [7:0] exp1 = '0;
  logic [7:0] tbl1 = '0;
  logic       y1;
  logic [2:0] abc1;
  logic       busy1, done1, pass1;
  logic [7:0] cap1;
  logic [3:0] err1;

  // Small instance: N_IN=2, SETTLE_CYC=1
  logic       start2 = 1'b0;
  logic [3:0] exp2 = '0;
  logic [3:0] tbl2 = '0;
  logic       y2;
  logic [1:0] abc2;
  logic       busy2, done2, pass2;
  logic [3:0] cap2;
  logic [2:0] err2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Combinational block under test: a truth table indexed by the stimulus.
  always_comb begin
    y1 = tbl1[abc1];
    y2 = tbl2[abc2];
  end

  tt_sweep_checker u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .expected(exp1), .y_in(y1),
    .abc_out(abc1), .busy(busy1), .done(done1), .pass(pass1),
    .captured(cap1), .err_count(err1)
  );

  tt_sweep_checker #(.N_IN(2), .SETTLE_CYC(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .expected(exp2), .y_in(y2),
    .abc_out(abc2), .busy(busy2), .done(done2), .pass(pass2),
    .captured(cap2), .err_count(err2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: captured table equals the DUT table, errors are differing bits.
  task automatic model(input logic [63:0] tbl, input logic [63:0] exp, input int v, input int s,
                       output logic [63:0] cap, output int err, output bit ps, output int len);
    cap = '0;
    err = 0;
    len = v * (s + 1);
    for (int i = 0; i < v; i++) begin
      cap[i] = tbl[i];
      if (tbl[i] != exp[i]) begin
        err++;
`ifdef TT_STOP_ON_FAIL_EN
        len = (i + 1) * (s + 1);
        break;
`endif
      end
    end
    ps = (err == 0);
  endtask

  // One sweep on the default instance, optionally with ignored starts
  // mid-sweep / a changed golden table, and a start on the DONE-entry edge.
  task automatic run_sweep(input logic [7:0] tbl, input logic [7:0] exp, input bit disturb, input bit late);
    logic [63:0] m_cap;
    int          m_err;
    bit          m_pass;
    int          len;
    model({56'd0, tbl}, {56'd0, exp}, 8, 2, m_cap, m_err, m_pass, len);
    tbl1   = tbl;
    exp1   = exp;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int t = 0; t <= len; t++) begin
      if (t < len) begin
        checks++;
        if (abc1 !== 3'(t / 3) || busy1 !== 1'b1 || done1 !== 1'b0) begin
          errors++;
          $display("FAIL sweep_step t=%0d abc=%0d busy=%b done=%b, required abc=%0d busy=1 done=0",
                   t, abc1, busy1, done1, t / 3);
        end
        start1 = (disturb && (t == 4 || t == 9)) || (late && t == len - 1);
        if (disturb && t == 7) exp1 = 8'hFF;
        tick();
      end else begin
        checks++;
        if (done1 !== 1'b1 || busy1 !== 1'b0 || pass1 !== m_pass || err1 !== 4'(m_err) ||
            cap1 !== m_cap[7:0] || abc1 !== 3'(len / 3 - 1)) begin
          errors++;
          $display("FAIL sweep_end done=%b busy=%b pass=%b err=%0d cap=%h abc=%0d, required 1 0 %b %0d %h %0d",
                   done1, busy1, pass1, err1, cap1, abc1, m_pass, m_err, m_cap[7:0], len / 3 - 1);
        end
      end
    end
    start1 = 1'b0;
    if (late) begin
      tick();
      checks++;
      if (done1 !== 1'b1 || busy1 !== 1'b0 || err1 !== 4'(m_err)) begin
        errors++;
        $display("FAIL late_start done=%b busy=%b err=%0d, required done=1 busy=0 err=%0d",
                 done1, busy1, err1, m_err);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({abc1, busy1, done1, pass1, cap1, err1} !== '0 ||
        {abc2, busy2, done2, pass2, cap2, err2} !== '0) begin
      errors++;
      $display("FAIL reset_state dut1=%h dut2=%h, required 0",
               {abc1, busy1, done1, pass1, cap1, err1}, {abc2, busy2, done2, pass2, cap2, err2});
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_xor_golden();
    run_sweep(8'b10010110, 8'b10010110, 1'b0, 1'b0);
  endtask

  task automatic test_stuck_at_zero();
    run_sweep(8'h00, 8'b10010110, 1'b0, 1'b0);
  endtask

  task automatic test_ignored_start();
    run_sweep(8'b10010110, 8'b10010110, 1'b1, 1'b1);
  endtask

  task automatic test_mid_reset();
    tbl1   = 8'b10010110;
    exp1   = 8'b10010110;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int t = 0; t < 15; t++) tick();
    checks++;
    if (abc1 !== 3'b101 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset abc=%0d busy=%b, required abc=5 busy=1", abc1, busy1);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({abc1, busy1, done1, pass1, cap1, err1} !== '0) begin
      errors++;
      $display("FAIL async_reset outputs=%h, required 0", {abc1, busy1, done1, pass1, cap1, err1});
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({abc1, busy1, done1, pass1, cap1, err1} !== '0) begin
      errors++;
      $display("FAIL post_reset_idle outputs=%h, required 0", {abc1, busy1, done1, pass1, cap1, err1});
    end
    run_sweep(8'b10010110, 8'b10010110, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_sweep(8'b10010110, 8'b10010110, 1'b0, 1'b0);
    run_sweep(8'b11110000, 8'b11110000, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      logic [7:0] tb;
      logic [7:0] ex;
      tb = 8'($urandom);
      ex = ($urandom_range(0, 1) == 1) ? tb : (tb ^ 8'($urandom_range(1, 255)));
      run_sweep(tb, ex, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_small_config();
    logic [3:0] tbs [3] = '{4'b1000, 4'b0110, 4'b1000};
    logic [3:0] exs [3] = '{4'b1000, 4'b1000, 4'b0000};
    for (int c = 0; c < 3; c++) begin
      logic [63:0] m_cap;
      int          m_err;
      bit          m_pass;
      int          len;
      model({60'd0, tbs[c]}, {60'd0, exs[c]}, 4, 1, m_cap, m_err, m_pass, len);
      tbl2   = tbs[c];
      exp2   = exs[c];
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      for (int t = 0; t < len; t++) begin
        checks++;
        if (abc2 !== 2'(t / 2) || busy2 !== 1'b1 || done2 !== 1'b0) begin
          errors++;
          $display("FAIL small_step t=%0d abc=%0d busy=%b done=%b, required abc=%0d busy=1 done=0",
                   t, abc2, busy2, done2, t / 2);
        end
        tick();
      end
      checks++;
      if (done2 !== 1'b1 || busy2 !== 1'b0 || pass2 !== m_pass || err2 !== 3'(m_err) ||
          cap2 !== m_cap[3:0]) begin
        errors++;
        $display("FAIL small_end done=%b busy=%b pass=%b err=%0d cap=%h, required 1 0 %b %0d %h",
                 done2, busy2, pass2, err2, cap2, m_pass, m_err, m_cap[3:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_xor_golden();
    test_stuck_at_zero();
    test_ignored_start();
    test_mid_reset();
    test_back_to_back();
    test_random();
    test_small_config();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
